memctrl_burst_writer: RTL and testbench

//  Memory-controller write stage sitting directly upstream of mem. Accepts a block-write request
//  (block base address + word count) and the block's data words from the uart/bus side. Buffers
//  the whole block, then drives mem's write-start / write-data handshake one word per accepted cycle.

---
 rtl/memctrl_burst_writer_pkg.sv | 9 +
 rtl/memctrl_word_buf.sv | 28 ++
 rtl/memctrl_burst_writer.sv | 117 +++++++++++
 tb/tb_memctrl_burst_writer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/memctrl_burst_writer_pkg.sv
// memctrl_burst_writer_pkg: shared widths, write-start encodings and FSM states for the burst writer.
package memctrl_burst_writer_pkg;
    localparam int BUS_ADDR_WIDTH = 32;
    localparam int WORD_WIDTH = 32;
    localparam int WORD_NUMBER_BIT = 3;
    localparam logic MEMCTRL_MEM_WRITE_START_ENABLE = 1'b1;
    localparam logic MEMCTRL_MEM_WRITE_START_DISABLE = 1'b0;
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_START, ST_STREAM} state_e;
endpackage

// File: rtl/memctrl_word_buf.sv
// memctrl_word_buf: block buffer with one write port, one registered read port and synchronous active-low clear.
module memctrl_word_buf #(
    parameter int DEPTH = 4,
    parameter int WORD_W = 32,
    parameter int AW = 2
) (
    input  logic              clk_i,
    input  logic              clear_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (!clear_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (we_i) mem_q[waddr_i] <= wdata_i;
            if (re_i) rdata_q <= mem_q[raddr_i];
        end
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/memctrl_burst_writer.sv
// memctrl_burst_writer: buffers a whole write block, then streams it to mem one word per ready cycle.
module memctrl_burst_writer
    import memctrl_burst_writer_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_WIDTH,
    parameter int WORD_W = WORD_WIDTH,
    parameter int MAX_WORDS = 4,
    parameter int CNT_W = WORD_NUMBER_BIT,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [CNT_W-1:0]  req_word_number_i,
    input  logic              wdata_valid_i,
    output logic              wdata_ready_o,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [ADDR_W-1:0] memctrl_mem_addr_o,
    output logic [CNT_W-1:0]  memctrl_word_number_o,
    output logic              memctrl_mem_write_start_o,
    output logic [WORD_W-1:0] memctrl_mem_write_data_o,
    input  logic              mem_memctrl_write_ready_i,
    output logic              wr_done_o,
    output logic              wr_err_o
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = MAX_WORDS > 1 ? $clog2(MAX_WORDS) : 1;
    state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [TW-1:0] to_q, to_d;
    logic done_q, done_d, err_q, err_d;
    logic ready, busy, last, timed_out, bad_req, buf_we, buf_re;
    logic [WORD_W-1:0] buf_rdata;
    assign ready = mem_memctrl_write_ready_i;
    assign busy = state_q == ST_START || state_q == ST_STREAM;
    assign rd_next = rd_ptr_q + CNT_W'(1);
    assign last = rd_ptr_q == cnt_q - CNT_W'(1);
    assign timed_out = to_q == TW'(TIMEOUT - 1);
    assign bad_req = req_word_number_i == '0 || req_word_number_i > CNT_W'(MAX_WORDS);
    assign buf_we = state_q == ST_FILL && wdata_valid_i;
    // Prefetch the next word on every accept so write data is valid the cycle STREAM is entered.
    assign buf_re = ready && (state_q == ST_START || (state_q == ST_STREAM && !last));
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        cnt_d = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        to_d = (ready || !busy) ? '0 : (to_q == '1 ? to_q : to_q + TW'(1));
        done_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid_i) begin
                addr_d = req_addr_i;
                cnt_d = req_word_number_i;
                wr_ptr_d = '0;
                err_d = bad_req;
                state_d = bad_req ? ST_IDLE : ST_FILL;
            end
            ST_FILL: if (wdata_valid_i) begin
                wr_ptr_d = wr_ptr_q + CNT_W'(1);
                state_d = wr_ptr_q == cnt_q - CNT_W'(1) ? ST_START : ST_FILL;
            end
            ST_START, ST_STREAM: if (ready) begin
                rd_ptr_d = state_q == ST_START ? '0 : rd_next;
                done_d = state_q == ST_STREAM && last;
                state_d = (state_q == ST_STREAM && last) ? ST_IDLE : ST_STREAM;
            end else if (timed_out) begin
                state_d = ST_IDLE;
                err_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            addr_q <= '0;
            cnt_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            to_q <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            to_q <= to_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end
    memctrl_word_buf #(.DEPTH(MAX_WORDS), .WORD_W(WORD_W), .AW(BW)) u_buf (
        .clk_i(clk_i),
        .clear_ni(reset_i),
        .we_i(buf_we),
        .waddr_i(wr_ptr_q[BW-1:0]),
        .wdata_i(wdata_i),
        .re_i(buf_re),
        .raddr_i(state_q == ST_START ? '0 : rd_next[BW-1:0]),
        .rdata_o(buf_rdata)
    );
    assign req_ready_o = state_q == ST_IDLE;
    assign wdata_ready_o = state_q == ST_FILL;
    assign memctrl_mem_addr_o = state_q == ST_IDLE ? '0 : addr_q;
    assign memctrl_word_number_o = state_q == ST_IDLE ? '0 : cnt_q;
    assign memctrl_mem_write_start_o = state_q == ST_START ? MEMCTRL_MEM_WRITE_START_ENABLE : MEMCTRL_MEM_WRITE_START_DISABLE;
    assign memctrl_mem_write_data_o = state_q == ST_STREAM ? buf_rdata : '0;
    assign wr_done_o = done_q;
    assign wr_err_o = err_q;
endmodule

// File: tb/tb_memctrl_burst_writer.sv
// tb_memctrl_burst_writer: scenario tasks checked against a word-queue model of the mem write protocol.
module tb_memctrl_burst_writer;
    localparam int TIMEOUT = 64;
    localparam int MAXW = 4;
    logic clk = 0, reset_n = 0;
    logic req_valid = 0, wdata_valid = 0, rdy = 0;
    logic [31:0] req_addr = 0, wdata = 0;
    logic [2:0] req_n = 0;
    logic req_ready, wdata_ready, write_start, wr_done, wr_err;
    logic [31:0] mem_addr, wdata_out;
    logic [2:0] word_number;
    int tests_run = 0, fails = 0;
    logic [31:0] word_q[$];
    logic [31:0] cur_addr;
    int cur_n, left, stall, accepted, start_cycles, ended;
    bit streaming = 0, pend_done = 0, pend_err = 0;

    memctrl_burst_writer dut (
        .clk_i(clk), .reset_i(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_word_number_i(req_n),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .memctrl_mem_addr_o(mem_addr), .memctrl_word_number_o(word_number),
        .memctrl_mem_write_start_o(write_start), .memctrl_mem_write_data_o(wdata_out),
        .mem_memctrl_write_ready_i(rdy), .wr_done_o(wr_done), .wr_err_o(wr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Observe the cycle about to be clocked, update the model, then advance to the next falling edge.
    task automatic tick();
        tests_run++;
        if (wr_done !== pend_done) begin fails++; $display("FAIL done_pulse: got %b want %b", wr_done, pend_done); end
        tests_run++;
        if (wr_err !== pend_err) begin fails++; $display("FAIL err_pulse: got %b want %b", wr_err, pend_err); end
        pend_done = 0;
        pend_err = 0;
        if (!reset_n) begin
            streaming = 0;
            stall = 0;
        end else begin
            if (req_valid && req_ready) begin
                if (req_n == 0 || req_n > MAXW) pend_err = 1;
                else begin cur_addr = req_addr; cur_n = req_n; left = req_n; end
            end
            if (streaming) begin
                tests_run++;
                if (wdata_out !== word_q[0] || mem_addr !== cur_addr || word_number !== 3'(cur_n) || req_ready !== 0 || write_start !== 0) begin
                    fails++;
                    $display("FAIL stream_beat: data %h addr %h num %0d rr %b ws %b want data %h addr %h num %0d rr 0 ws 0",
                             wdata_out, mem_addr, word_number, req_ready, write_start, word_q[0], cur_addr, cur_n);
                end
                if (rdy) begin
                    void'(word_q.pop_front());
                    accepted++;
                    left--;
                    stall = 0;
                    if (left == 0) begin streaming = 0; pend_done = 1; ended = 1; end
                end
            end else if (write_start && rdy) begin
                streaming = 1;
                stall = 0;
            end
            if (write_start) start_cycles++;
            if ((write_start || streaming) && !rdy) begin
                stall++;
                if (stall == TIMEOUT) begin pend_err = 1; streaming = 0; stall = 0; ended = 2; word_q.delete(); end
            end
        end
        @(negedge clk);
    endtask

    task automatic run_burst(input logic [31:0] addr, input int n, input int mode, input logic [31:0] mask,
                             input int rst_after, input bit seq, input bit hold, input logic [31:0] naddr, input int nn);
        int k;
        logic [31:0] w;
        ended = 0;
        accepted = 0;
        start_cycles = 0;
        req_valid = 1;
        req_addr = addr;
        req_n = 3'(n);
        tests_run++;
        if (req_ready !== 1) begin fails++; $display("FAIL req_accept: req_ready %b want 1", req_ready); end
        tick();
        req_valid = 0;
        if (n == 0 || n > MAXW) begin
            tests_run++;
            if ({wr_err, write_start, req_ready} !== 3'b101) begin
                fails++;
                $display("FAIL bad_request n=%0d: err/start/req_ready %b want 101", n, {wr_err, write_start, req_ready});
            end
            return;
        end
        for (int i = 0; i < n;) begin
            if ($urandom_range(0, 3) == 0) begin
                wdata_valid = 0;
                tick();
            end else begin
                w = seq ? 32'(i) : $urandom;
                word_q.push_back(w);
                wdata_valid = 1;
                wdata = w;
                tests_run++;
                if (wdata_ready !== 1) begin fails++; $display("FAIL fill_ready: got %b want 1", wdata_ready); end
                tick();
                i++;
            end
        end
        wdata_valid = 0;
        tests_run++;
        if (wdata_ready !== 0) begin fails++; $display("FAIL fill_end: wdata_ready %b want 0", wdata_ready); end
        k = 0;
        while (ended == 0 && k < 400) begin
            if (rst_after > 0 && accepted == rst_after) begin
                reset_n = 0;
                tick();
                reset_n = 1;
                word_q.delete();
                tests_run++;
                if ({req_ready, wdata_ready, write_start, wr_done, wr_err} !== 5'b10000 || wdata_out !== 0 || mem_addr !== 0 || word_number !== 0) begin
                    fails++;
                    $display("FAIL reset_mid: rr/wr/ws/done/err %b data %h addr %h num %0d want 10000 0 0 0",
                             {req_ready, wdata_ready, write_start, wr_done, wr_err}, wdata_out, mem_addr, word_number);
                end
                repeat (3) tick();
                return;
            end
            case (mode)
                0: rdy = 1;
                1: rdy = !(k < 32 && mask[k]);
                2: rdy = $urandom_range(0, 3) != 0;
                default: rdy = 0;
            endcase
            if (hold) begin req_valid = 1; req_addr = naddr; req_n = 3'(nn); end
            tick();
            k++;
        end
        rdy = 0;
        tests_run++;
        if (ended == 0) begin fails++; $display("FAIL burst_budget: no done or err within 400 cycles"); end
        else if (ended == 1 && wr_done !== 1) begin fails++; $display("FAIL done_end: wr_done %b want 1", wr_done); end
        else if (ended == 2 && wr_err !== 1) begin fails++; $display("FAIL timeout_end: wr_err %b want 1", wr_err); end
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({req_ready, wdata_ready, write_start, wr_done, wr_err} !== 5'b10000 || wdata_out !== 0 || mem_addr !== 0 || word_number !== 0) begin
            fails++;
            $display("FAIL reset_state: rr/wr/ws/done/err %b data %h addr %h num %0d want 10000 0 0 0",
                     {req_ready, wdata_ready, write_start, wr_done, wr_err}, wdata_out, mem_addr, word_number);
        end
        reset_n = 1;
        tick();
    endtask

    task automatic test_basic();
        run_burst(32'd4, 4, 0, 0, 0, 1, 0, 0, 0);
        tests_run++;
        if (start_cycles != 1 || accepted != 4) begin
            fails++;
            $display("FAIL basic: start cycles %0d accepts %0d want 1 4", start_cycles, accepted);
        end
        tick();
    endtask

    task automatic test_stall();
        run_burst(32'd4, 4, 1, 32'h4, 0, 1, 0, 0, 0);
        tests_run++;
        if (start_cycles != 1 || accepted != 4) begin
            fails++;
            $display("FAIL stall: start cycles %0d accepts %0d want 1 4", start_cycles, accepted);
        end
        tick();
    endtask

    task automatic test_bad_request();
        run_burst(32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        run_burst(32'h80, 5, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_timeout();
        run_burst(32'h100, 2, 3, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (start_cycles != TIMEOUT || ended != 2) begin
            fails++;
            $display("FAIL timeout: start cycles %0d end %0d want %0d 2", start_cycles, ended, TIMEOUT);
        end
        tick();
        run_burst(32'h200, 3, 2, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid_stream();
        run_burst(32'h300, 4, 0, 0, 2, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_burst(32'h400, 4, 2, 0, 0, 0, 1, 32'h500, 3);
        run_burst(32'h500, 3, 2, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            run_burst($urandom, int'($urandom_range(0, 6)), 2, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_bad_request();
        test_timeout();
        test_reset_mid_stream();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
